fp_subr: RTL and testbench

//  Pipelined subtractor: out = first - second, for the 27-bit {sign,expt[7:0],mant[17:0]} float format used by the adder path.

---
 rtl/fp_subr_if.sv | 27 ++
 rtl/fp_subr.sv | 149 ++++++++++++++
 tb/tb_fp_subr.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_subr_if.sv
// Operand/result handshake bundle for the fp_subr pipelined subtractor.
interface fp_subr_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 18
);
    localparam int unsigned W = 1 + EXP_W + MAN_W;

    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] first;
    logic [W-1:0] second;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out;
    logic         out_zero;
    logic         out_ovf;

    modport master (
        output in_valid, first, second, out_ready,
        input  in_ready, out_valid, out, out_zero, out_ovf
    );

    modport slave (
        input  in_valid, first, second, out_ready,
        output in_ready, out_valid, out, out_zero, out_ovf
    );
endinterface

// File: rtl/fp_subr.sv
// Three-stage pipelined float subtractor, out = first - second on {sign, expt, mant} words.
// Alignment truncates; results are left-normalised, overflow saturates, underflow flushes to zero.
module fp_subr #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 18
) (
    input logic      clk,
    input logic      rst,
    fp_subr_if.slave bus
);
    localparam int unsigned W   = 1 + EXP_W + MAN_W;
    localparam int unsigned MW  = MAN_W + 1;
    localparam int unsigned SW  = MAN_W + 2;
    localparam int unsigned LZW = $clog2(MW + 1);

    logic adv;
    assign adv          = ~bus.out_valid | bus.out_ready;
    assign bus.in_ready = adv;

    // S1: negate the subtrahend and order operands by magnitude
    logic             a_sign, b_sign, a_zero, b_zero, swap;
    logic [EXP_W-1:0] a_exp, b_exp;
    logic [MAN_W-1:0] a_man, b_man;
    logic             big_s_d, small_s_d;
    logic [EXP_W-1:0] big_e_d, small_e_d;
    logic [MW-1:0]    big_m_d, small_m_d;

    assign {a_sign, a_exp, a_man} = bus.first;
    assign b_sign = ~bus.second[W-1];
    assign b_exp  = bus.second[W-2 -: EXP_W];
    assign b_man  = bus.second[MAN_W-1:0];
    assign a_zero = (a_exp == '0);
    assign b_zero = (b_exp == '0);
    assign swap   = {b_exp, b_man} > {a_exp, a_man};

    always_comb begin
        big_s_d   = a_sign;
        big_e_d   = a_exp;
        big_m_d   = {1'b1, a_man};
        small_s_d = b_sign;
        small_e_d = b_exp;
        small_m_d = b_zero ? '0 : {1'b1, b_man};
        if (swap) begin
            big_s_d   = b_sign;
            big_e_d   = b_exp;
            big_m_d   = {1'b1, b_man};
            small_s_d = a_sign;
            small_e_d = a_exp;
            small_m_d = a_zero ? '0 : {1'b1, a_man};
        end
    end

    logic             s1_valid_q, s1_zero_q, s1_sub_q, s1_sign_q;
    logic [EXP_W-1:0] s1_exp_q, s1_d_q;
    logic [MW-1:0]    s1_big_q, s1_small_q;

    // S2: align the smaller mantissa and add/subtract; |big| >= |small| so no borrow out
    logic [MW-1:0] aligned;
    logic [SW-1:0] sum_d;

    assign aligned = (s1_d_q <= EXP_W'(MAN_W)) ? (s1_small_q >> s1_d_q) : '0;
    assign sum_d   = s1_sub_q ? ({1'b0, s1_big_q} - {1'b0, aligned})
                              : ({1'b0, s1_big_q} + {1'b0, aligned});

    logic             s2_valid_q, s2_zero_q, s2_sign_q;
    logic [EXP_W-1:0] s2_exp_q;
    logic [SW-1:0]    s2_sum_q;

    // S3: normalise, then classify as overflow, zero/underflow or normal
    logic [LZW-1:0]   lz;
    logic [MAN_W-1:0] norm;
    logic [EXP_W-1:0] exp_inc;
    logic [W-1:0]     out_d;
    logic             zero_d, ovf_d;

    always_comb begin
        lz = LZW'(MW);
        for (int unsigned i = 0; i < MW; i++) begin
            if (s2_sum_q[i]) lz = LZW'(MW - 1 - i);
        end
        norm    = MAN_W'(s2_sum_q[MW-1:0] << lz);
        exp_inc = s2_exp_q + EXP_W'(1);
        out_d   = '0;
        zero_d  = 1'b0;
        ovf_d   = 1'b0;
        if (s2_zero_q || (s2_sum_q == '0)) begin
            zero_d = 1'b1;
        end else if (s2_sum_q[SW-1]) begin
            if (s2_exp_q == '1) begin
                out_d = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b1}}};
                ovf_d = 1'b1;
            end else begin
                out_d = {s2_sign_q, exp_inc, s2_sum_q[MAN_W:1]};
            end
        end else if (s2_exp_q <= EXP_W'(lz)) begin
            zero_d = 1'b1;
        end else begin
            out_d = {s2_sign_q, s2_exp_q - EXP_W'(lz), norm};
        end
    end

    logic         out_valid_q, out_zero_q, out_ovf_q;
    logic [W-1:0] out_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid_q  <= 1'b0;
            s1_zero_q   <= 1'b0;
            s1_sub_q    <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_exp_q    <= '0;
            s1_d_q      <= '0;
            s1_big_q    <= '0;
            s1_small_q  <= '0;
            s2_valid_q  <= 1'b0;
            s2_zero_q   <= 1'b0;
            s2_sign_q   <= 1'b0;
            s2_exp_q    <= '0;
            s2_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_zero_q  <= 1'b0;
            out_ovf_q   <= 1'b0;
            out_q       <= '0;
        end else if (adv) begin
            s1_valid_q  <= bus.in_valid;
            s1_zero_q   <= a_zero & b_zero;
            s1_sub_q    <= big_s_d ^ small_s_d;
            s1_sign_q   <= big_s_d;
            s1_exp_q    <= big_e_d;
            s1_d_q      <= big_e_d - small_e_d;
            s1_big_q    <= big_m_d;
            s1_small_q  <= small_m_d;
            s2_valid_q  <= s1_valid_q;
            s2_zero_q   <= s1_zero_q;
            s2_sign_q   <= s1_sign_q;
            s2_exp_q    <= s1_exp_q;
            s2_sum_q    <= sum_d;
            out_valid_q <= s2_valid_q;
            out_zero_q  <= zero_d;
            out_ovf_q   <= ovf_d;
            out_q       <= out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_zero  = out_zero_q;
    assign bus.out_ovf   = out_ovf_q;
    assign bus.out       = out_q;
endmodule

// File: tb/tb_fp_subr.sv
// Self-checking bench for fp_subr: directed corner cases plus randomized traffic with backpressure,
// checked against an integer-arithmetic reference model through an in-order expectation queue.
module tb_fp_subr;
    logic clk;
    logic rst;

    fp_subr_if bus ();

    fp_subr dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Expected {ovf, zero, out} per accepted operation, in acceptance order.
    logic [28:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: got %0h, want %0h", tag, got, want);
        end
    endtask

    function automatic logic [26:0] mk(input bit s, input int e, input int m);
        return {s, 8'(e), 18'(m)};
    endfunction

    // Reference: real-valued magnitudes as scaled integers, truncating alignment of the smaller one.
    function automatic logic [28:0] model(input logic [26:0] f, input logic [26:0] s);
        int     ea, eb, e, d;
        longint ma, mb, big, sml, al, sum;
        bit     sa, sb, sg;
        sa = f[26];
        ea = int'(f[25:18]);
        ma = (ea == 0) ? 0 : (longint'(1) << 18) + longint'(f[17:0]);
        sb = ~s[26];
        eb = int'(s[25:18]);
        mb = (eb == 0) ? 0 : (longint'(1) << 18) + longint'(s[17:0]);
        if (ea == 0 && eb == 0) return {2'b01, 27'd0};
        if (ea > eb || (ea == eb && ma >= mb)) begin
            big = ma; sml = mb; e = ea; sg = sa; d = ea - eb;
        end else begin
            big = mb; sml = ma; e = eb; sg = sb; d = eb - ea;
        end
        al  = (d <= 18) ? (sml >> d) : 0;
        sum = (sa != sb) ? big - al : big + al;
        if (sum == 0) return {2'b01, 27'd0};
        while (sum >= (longint'(1) << 19)) begin sum = sum >> 1; e++; end
        while (sum < (longint'(1) << 18)) begin sum = sum << 1; e--; end
        if (e > 255) return {2'b10, sg, 8'hFF, 18'h3FFFF};
        if (e <= 0) return {2'b01, 27'd0};
        return {2'b00, sg, 8'(e), 18'(sum)};
    endfunction

    task automatic gen(output logic [26:0] f, output logic [26:0] s);
        int ea, eb;
        case ($urandom_range(0, 5))
            0:       ea = int'($urandom_range(0, 3));
            1:       ea = int'($urandom_range(250, 255));
            default: ea = int'($urandom_range(1, 255));
        endcase
        eb = ea + int'($urandom_range(0, 24)) - 12;
        if (eb < 0) eb = 0;
        if (eb > 255) eb = 255;
        if ($urandom_range(0, 9) == 0) eb = 0;
        f = {1'($urandom_range(0, 1)), 8'(ea), 18'($urandom)};
        s = {1'($urandom_range(0, 1)), 8'(eb),
             ($urandom_range(0, 3) == 0) ? f[17:0] ^ 18'($urandom_range(0, 7)) : 18'($urandom)};
    endtask

    // Present one op at the current negedge, wait (bounded) for acceptance, leave at next negedge.
    task automatic send1(input logic [26:0] f, input logic [26:0] s, input logic [28:0] want);
        int n;
        n            = 0;
        bus.in_valid = 1'b1;
        bus.first    = f;
        bus.second   = s;
        #1;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 50) chk("accept_timeout", 32'(bus.in_ready), 1);
        else exp_q.push_back(want);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic latency_after_send();
        #1 chk("lat_edge1_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        #1 chk("lat_edge2_valid", 32'(bus.out_valid), 0);
        @(negedge clk);
        #1 chk("lat_edge3_valid", 32'(bus.out_valid), 1);
    endtask

    // Monitor: sample mid-cycle, after the driver has settled out_ready for the coming edge.
    logic [28:0] prev_out;
    logic [28:0] popped;
    bit          stall = 1'b0;

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            stall = 1'b0;
        end else begin
            if (stall) begin
                chk("hold_valid", 32'(bus.out_valid), 1);
                chk("hold_data", 32'({bus.out_ovf, bus.out_zero, bus.out}), 32'(prev_out));
            end
            if (bus.out_valid) chk("flags_exclusive", 32'(bus.out_ovf & bus.out_zero), 0);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    popped = exp_q.pop_front();
                    chk("out", 32'(bus.out), 32'(popped[26:0]));
                    chk("flags", 32'({bus.out_ovf, bus.out_zero}), 32'(popped[28:27]));
                end
            end
            stall    = bus.out_valid && !bus.out_ready;
            prev_out = {bus.out_ovf, bus.out_zero, bus.out};
        end
    end

    logic [26:0] rf, rs;
    bit          accepted;
    int          n;

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.first     = '0;
        bus.second    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out", 32'(bus.out), 0);
        chk("rst_flags", 32'({bus.out_ovf, bus.out_zero}), 0);
        chk("rst_in_ready", 32'(bus.in_ready), 1);
        @(negedge clk);

        // Exact-power subtraction with latency check
        send1(mk(0, 130, 0), mk(0, 129, 0), {2'b00, mk(0, 129, 0)});
        latency_after_send();
        @(negedge clk);

        // Cancellation, deep renormalisation, sign swap, effective add
        send1(mk(0, 140, 'h2A5A5), mk(0, 140, 'h2A5A5), {2'b01, 27'h0});
        send1(mk(0, 130, 1), mk(0, 130, 0), {2'b00, mk(0, 112, 0)});
        send1(mk(0, 129, 0), mk(0, 130, 0), {2'b00, mk(1, 129, 0)});
        send1(mk(0, 130, 0), mk(1, 130, 0), {2'b00, mk(0, 131, 0)});
        // Overflow saturation, zero subtrahend, d=19 alignment loss
        send1(mk(0, 255, 'h3FFFF), mk(1, 255, 'h3FFFF), {2'b10, mk(0, 255, 'h3FFFF)});
        send1(mk(0, 100, 0), mk(0, 0, 'h123), {2'b00, mk(0, 100, 0)});
        send1(mk(0, 150, 5), mk(0, 131, 'h3FFFF), {2'b00, mk(0, 150, 5)});
        // Underflow, zero minuend, both zero with junk mantissas
        send1(mk(0, 5, 0), mk(0, 5, 1), {2'b01, 27'h0});
        send1(mk(0, 0, 0), mk(0, 120, 3), {2'b00, mk(1, 120, 3)});
        send1(mk(1, 0, 5), mk(0, 0, 7), {2'b01, 27'h0});
        repeat (5) @(negedge clk);

        // Six back-to-back ops with out_ready low in cycles 4-7
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    gen(rf, rs);
                    bus.in_valid = 1'b1;
                    bus.first    = rf;
                    bus.second   = rs;
                    #1;
                    n = 0;
                    while (!bus.in_ready && n < 50) begin
                        @(negedge clk);
                        #1;
                        n++;
                    end
                    if (n >= 50) chk("bp_accept_timeout", 32'(bus.in_ready), 1);
                    else exp_q.push_back(model(rf, rs));
                    @(negedge clk);
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 10; c++) begin
                    bus.out_ready = !(c >= 4 && c <= 7);
                    #1;
                    if (c >= 4) chk("bp_in_ready", 32'(bus.in_ready), (c <= 7) ? 0 : 1);
                    @(negedge clk);
                end
                bus.out_ready = 1'b1;
            end
        join
        repeat (6) @(negedge clk);
        chk("bp_drained", 32'(exp_q.size()), 0);

        // Reset with three ops in flight, then a fresh op
        for (int i = 0; i < 3; i++) begin
            gen(rf, rs);
            send1(rf, rs, model(rf, rs));
        end
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 0);
        chk("midrst_out", 32'(bus.out), 0);
        chk("midrst_flags", 32'({bus.out_ovf, bus.out_zero}), 0);
        @(negedge clk);
        send1(mk(0, 130, 0), mk(1, 130, 0), {2'b00, mk(0, 131, 0)});
        latency_after_send();
        @(negedge clk);

        // Randomized traffic with random backpressure
        bus.in_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            bus.out_ready = ($urandom_range(0, 3) != 0);
            if (!bus.in_valid && $urandom_range(0, 4) != 0) begin
                gen(rf, rs);
                bus.first    = rf;
                bus.second   = rs;
                bus.in_valid = 1'b1;
            end
            #1;
            accepted = bus.in_valid && bus.in_ready;
            if (accepted) exp_q.push_back(model(bus.first, bus.second));
            @(negedge clk);
            if (accepted) bus.in_valid = 1'b0;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        #3;
        chk("final_drained", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
